// File: rtl/lut_cfg_pkg.sv
// Shared types and sizing helpers for the LUT configuration-chain loader.
package lut_cfg_pkg;

  typedef enum logic [2:0] {IDLE, WAIT, SHIFT, DONE, ERR} state_e;

  localparam int LUT_K_DEF = 4;
  localparam int LUT_BITS  = 2**LUT_K_DEF;

  // Word counter must hold 0..NUM_LUTS-1 with one bit of headroom.
  function automatic int wcnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/lut_cfg_serializer.sv
// Truth-table shifter: loads one word and streams it MSB-first over 2**LUT_K cycles.
module lut_cfg_serializer #(
  parameter int LUT_K = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [(2**LUT_K)-1:0] data,
  output logic                  busy,
  output logic                  last_bit,
  output logic                  sout
);

  localparam int BITS = 2**LUT_K;

  logic [BITS-1:0]  sreg_q, sreg_d;
  logic [LUT_K-1:0] bit_cnt_q, bit_cnt_d;
  logic             busy_q, busy_d;

  // Load restarts the count; otherwise shift while busy and stop after the last bit.
  always_comb begin
    sreg_d    = sreg_q;
    bit_cnt_d = bit_cnt_q;
    busy_d    = busy_q;
    if (load) begin
      sreg_d    = data;
      bit_cnt_d = '0;
      busy_d    = 1'b1;
    end else if (busy_q) begin
      sreg_d    = sreg_q << 1;
      bit_cnt_d = bit_cnt_q + LUT_K'(1);
      if (&bit_cnt_q) busy_d = 1'b0;
    end
  end

  // Shifter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q    <= '0;
      bit_cnt_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      sreg_q    <= sreg_d;
      bit_cnt_q <= bit_cnt_d;
      busy_q    <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign last_bit = busy_q && (&bit_cnt_q);
  assign sout     = sreg_q[BITS-1];

endmodule

// File: rtl/lut4_cfg_loader.sv
// Session controller: accepts NUM_LUTS truth tables and streams them onto the ccff chain.
module lut4_cfg_loader
  import lut_cfg_pkg::*;
#(
  parameter int NUM_LUTS = 4,
  parameter int LUT_K    = LUT_K_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [(2**LUT_K)-1:0] cfg_data,
  input  logic                  cfg_last,
  output logic                  ccff_head,
  output logic                  ccff_en,
  output logic                  prog_en,
  output logic                  busy,
  output logic                  cfg_done,
  output logic                  done_pulse,
  output logic                  cfg_error
);

  localparam int WCW = wcnt_w(NUM_LUTS);
  localparam logic [WCW-1:0] LAST_WORD = WCW'(NUM_LUTS - 1);

  state_e         state_q, state_d;
  logic [WCW-1:0] word_cnt_q, word_cnt_d;
  logic           last_q, last_d;
  logic           done_pulse_q, done_pulse_d;
  logic           ser_load, ser_busy, ser_last, ser_out;

  lut_cfg_serializer #(.LUT_K(LUT_K)) u_ser (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ser_load),
    .data     (cfg_data),
    .busy     (ser_busy),
    .last_bit (ser_last),
    .sout     (ser_out)
  );

  // Next-state: word count and the captured last flag decide the outcome on the final shift.
  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    last_d     = last_q;
    ser_load   = 1'b0;
    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d    = WAIT;
          word_cnt_d = '0;
        end
      end
      WAIT: begin
        if (cfg_valid) begin
          ser_load = 1'b1;
          last_d   = cfg_last;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (ser_last) begin
          if (last_q && word_cnt_q == LAST_WORD)      state_d = DONE;
          else if (last_q || word_cnt_q == LAST_WORD) state_d = ERR;
          else begin
            word_cnt_d = word_cnt_q + WCW'(1);
            state_d    = WAIT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    done_pulse_d = (state_d == DONE) && (state_q != DONE);
  end

  // Controller registers; outputs below decode only from these flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      word_cnt_q   <= '0;
      last_q       <= 1'b0;
      done_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_cnt_q   <= word_cnt_d;
      last_q       <= last_d;
      done_pulse_q <= done_pulse_d;
    end
  end

  assign cfg_ready  = (state_q == WAIT);
  assign ccff_en    = ser_busy;
  assign ccff_head  = ser_busy & ser_out;
  assign busy       = (state_q == WAIT) || (state_q == SHIFT);
  // ERR keeps the fabric gated because the chain holds a partial load.
  assign prog_en    = busy || (state_q == ERR);
  assign cfg_done   = (state_q == DONE);
  assign cfg_error  = (state_q == ERR);
  assign done_pulse = done_pulse_q;

endmodule

// File: tb/tb_lut4_cfg_loader.sv
// Self-checking bench for lut4_cfg_loader: transaction-level model plus directed/random sessions.
module tb_lut4_cfg_loader;

  localparam int N = 4;
  localparam int B = 16;

  logic          clk, rst_n, start, cfg_valid, cfg_last;
  logic [B-1:0]  cfg_data;
  logic          cfg_ready, ccff_head, ccff_en, prog_en, busy, cfg_done, done_pulse, cfg_error;

  lut4_cfg_loader #(.NUM_LUTS(N), .LUT_K(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_data(cfg_data), .cfg_last(cfg_last), .ccff_head(ccff_head), .ccff_en(ccff_en),
    .prog_en(prog_en), .busy(busy), .cfg_done(cfg_done), .done_pulse(done_pulse),
    .cfg_error(cfg_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- session-level reference model ----------------
  // Session phases: 0 idle, 1 awaiting word, 2 streaming, 3 done, 4 error.
  int m_phase = 0;
  bit m_bits[$];
  int m_words = 0;
  bit m_last  = 0;
  bit m_pulse = 0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_phase = 0; m_bits.delete(); m_words = 0; m_last = 0; m_pulse = 0;
    end else begin
      m_pulse = 0;
      if (m_phase == 0 || m_phase == 3 || m_phase == 4) begin
        if (start) begin m_phase = 1; m_words = 0; end
      end else if (m_phase == 1) begin
        if (cfg_valid) begin
          for (int i = B-1; i >= 0; i--) m_bits.push_back(cfg_data[i]);
          m_last = cfg_last;
          m_words++;
          m_phase = 2;
        end
      end else begin
        void'(m_bits.pop_front());
        if (m_bits.size() == 0) begin
          if (m_last && m_words == N)      begin m_phase = 3; m_pulse = 1; end
          else if (m_last || m_words == N) m_phase = 4;
          else                             m_phase = 1;
        end
      end
    end
  end

  // Every cycle: all outputs against the model.
  initial forever begin
    logic [7:0] exp, act;
    @(negedge clk);
    exp[7] = (m_phase == 1);
    exp[6] = (m_phase == 2);
    exp[5] = (m_phase == 2 && m_bits.size() > 0) ? m_bits[0] : 1'b0;
    exp[4] = (m_phase == 1 || m_phase == 2 || m_phase == 4);
    exp[3] = (m_phase == 1 || m_phase == 2);
    exp[2] = (m_phase == 3);
    exp[1] = m_pulse;
    exp[0] = (m_phase == 4);
    act = {cfg_ready, ccff_en, ccff_head, prog_en, busy, cfg_done, done_pulse, cfg_error};
    chk("outputs{rdy,en,head,prog,busy,done,pulse,err}", 64'(act), 64'(exp));
  end

  // Downstream chain: LUT0 sits at the head, so LUT i = chain[16*i +: 16].
  logic [N*B-1:0] chain = '0;
  int shift_cnt = 0;
  int pulse_cnt = 0;
  initial forever begin
    @(negedge clk);
    if (ccff_en) begin chain = {chain[N*B-2:0], ccff_head}; shift_cnt++; end
    if (done_pulse) pulse_cnt++;
  end

  // ---------------- stimulus helpers (all called at a negedge) ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1; @(negedge clk); start = 1'b0;
  endtask

  task automatic send_word(input logic [B-1:0] d, input bit last);
    bit ok = 0;
    cfg_valid = 1'b1; cfg_data = d; cfg_last = last;
    for (int i = 0; i < 200; i++) begin
      if (cfg_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) chk("handshake_timeout", 64'd0, 64'd1);
    @(negedge clk);
    cfg_valid = 1'b0; cfg_last = 1'b0; cfg_data = $urandom();
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 200; i++) begin
      if (cfg_ready) return;
      @(negedge clk);
    end
    chk("ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_end();
    for (int i = 0; i < 500; i++) begin
      if (cfg_done || cfg_error) return;
      @(negedge clk);
    end
    chk("end_timeout", 64'd0, 64'd1);
  endtask

  task automatic nominal_load(input bit gaps);
    int s0, p0;
    logic [B-1:0] w [4];
    w[0] = 16'h0001; w[1] = 16'h8000; w[2] = 16'hFFFE; w[3] = 16'h6996;
    #1; s0 = shift_cnt; p0 = pulse_cnt;
    @(negedge clk);
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      send_word(w[i], i == 3);
      if (gaps && i < 3) begin
        int sg;
        if (i == 1) begin tick(3); pulse_start(); end
        wait_ready();
        #1; sg = shift_cnt;
        tick(10);
        #1; chk("gap_no_shift", 64'(shift_cnt), 64'(sg));
        @(negedge clk);
      end
    end
    wait_end();
    tick(3); #1;
    chk("lut3", 64'(chain[48 +: 16]), 64'h0001);
    chk("lut2", 64'(chain[32 +: 16]), 64'h8000);
    chk("lut1", 64'(chain[16 +: 16]), 64'hFFFE);
    chk("lut0", 64'(chain[0  +: 16]), 64'h6996);
    chk("nominal_shifts", 64'(shift_cnt - s0), 64'd64);
    chk("done_pulses", 64'(pulse_cnt - p0), 64'd1);
    chk("done_level", 64'(cfg_done), 64'd1);
    chk("prog_en_after_done", 64'(prog_en), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int s0;
    rst_n = 1'b0; start = 1'b0; cfg_valid = 1'b0; cfg_last = 1'b0; cfg_data = '0;
    tick(3);
    chk("reset_outputs", 64'({cfg_ready, ccff_en, ccff_head, prog_en, busy, cfg_done, done_pulse, cfg_error}), 64'd0);
    rst_n = 1'b1;
    tick(2);

    // Nominal 4-word load.
    nominal_load(1'b0);

    // Short stream: last on word 2.
    #1; s0 = shift_cnt;
    @(negedge clk);
    pulse_start();
    send_word(16'h1234, 1'b0);
    send_word(16'hABCD, 1'b1);
    wait_end(); #1;
    chk("short_shifts", 64'(shift_cnt - s0), 64'd32);
    chk("short_err", 64'({cfg_error, cfg_done, prog_en}), 64'b101);
    @(negedge clk);

    // Restart from ERR clears the error on the next cycle.
    start = 1'b1; @(negedge clk); start = 1'b0;
    chk("err_cleared", 64'(cfg_error), 64'd0);
    rst_n = 1'b0; tick(1); rst_n = 1'b1; tick(1);

    // Backpressure gaps plus an ignored start during SHIFT.
    nominal_load(1'b1);

    // Long stream: no last by word 4, then a 5th word is refused.
    #1; s0 = shift_cnt;
    @(negedge clk);
    pulse_start();
    for (int i = 0; i < 4; i++) send_word(16'(i * 16'h1111), 1'b0);
    wait_end(); #1;
    chk("long_shifts", 64'(shift_cnt - s0), 64'd64);
    chk("long_err", 64'(cfg_error), 64'd1);
    @(negedge clk);
    cfg_valid = 1'b1; cfg_data = 16'hDEAD;
    tick(2);
    chk("long_fifth_not_ready", 64'(cfg_ready), 64'd0);
    cfg_valid = 1'b0;
    tick(1);

    // Reset during bit 7 of word 2.
    pulse_start();
    send_word(16'hA5A5, 1'b0);
    send_word(16'h5A5A, 1'b0);
    tick(7);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", 64'({cfg_ready, ccff_en, ccff_head, prog_en, busy, cfg_done, done_pulse, cfg_error}), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    tick(1);
    nominal_load(1'b0);

    // Randomised sessions.
    for (int s = 0; s < 12; s++) begin
      int nw;
      bit longs, ok_end;
      logic [B-1:0] w [4];
      longs = ($urandom_range(0, 3) == 0);
      nw = longs ? N : $urandom_range(1, N);
      pulse_start();
      for (int i = 0; i < nw; i++) begin
        w[i] = B'($urandom());
        send_word(w[i], !longs && i == nw - 1);
        if ($urandom_range(0, 3) == 0) begin tick(2); pulse_start(); end
        tick($urandom_range(0, 20));
      end
      wait_end(); #1;
      ok_end = !longs && nw == N;
      chk("rand_done", 64'(cfg_done), 64'(ok_end));
      chk("rand_err", 64'(cfg_error), 64'(!ok_end));
      if (ok_end) chk("rand_chain", 64'(chain), {w[0], w[1], w[2], w[3]});
      @(negedge clk);
    end

    tick(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
